// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter.
// Holds the control FSM state encoding and the subtractor slice width.
// Imported by down_counter; fsub_4bit is fixed at 4 bits and needs nothing from it.
package down_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Every arithmetic slice in the decrement chain is this many bits wide.
    localparam int SLICE_W = 4;

endpackage : down_counter_pkg

// File: rtl/fsub_4bit.sv
// 4-bit ripple-borrow subtractor slice: d_o = a_i - b_i - bw_i.
// Purely combinational, zero latency; no handshake, so no backpressure.
// Ports: a_i/b_i operands, bw_i borrow in, d_o difference, bw_o borrow out.
module fsub_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       bw_i,
    output logic [3:0] d_o,
    output logic       bw_o
);

    logic [4:0] bw;

    assign bw[0] = bw_i;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign d_o[i]    = a_i[i] ^ b_i[i] ^ bw[i];
        // Borrow when a < b at this bit, or when a == b and a borrow arrives from below.
        assign bw[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
    end

    assign bw_o = bw[4];

endmodule : fsub_4bit

// File: rtl/down_counter.sv
// Loadable down-counter/timer with IDLE/RUN/DONE control and a registered terminal-count pulse.
// Latency: a load or decrement appears on cnt_o one clock after the cycle that requests it.
// Backpressure: none; en_i is a tick qualifier and stop_i > start_i > en_i every cycle.
// Ports: clk_i, rst_ni (async, active-low), start_i, stop_i, en_i, load_val_i -> cnt_o, busy_o, tc_o, done_o.
// Build option: define DOWN_COUNTER_AUTORELOAD_EN to reload the start value at terminal count and keep running.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);

    localparam int NSLICE = WIDTH / SLICE_W;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
        $error("down_counter: WIDTH must be a non-zero multiple of 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic             tc_q,    tc_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // ------------------------------------------------------------------
    // Decrement datapath: cnt - 1 through the chained subtractor slices.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  one_val;
    logic [WIDTH-1:0]  cnt_dec;
    logic [NSLICE:0]   bw_chain;

    assign one_val     = WIDTH'(1);
    assign bw_chain[0] = 1'b0;

    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        fsub_4bit u_fsub (
            .a_i  (cnt_q  [s*SLICE_W +: SLICE_W]),
            .b_i  (one_val[s*SLICE_W +: SLICE_W]),
            .bw_i (bw_chain[s]),
            .d_o  (cnt_dec[s*SLICE_W +: SLICE_W]),
            .bw_o (bw_chain[s+1])
        );
    end

    // A borrow out of the top slice would mean decrementing from zero; the FSM
    // never asks for that, and this guard makes a wrap impossible regardless.
    logic dec_underflow;
    assign dec_underflow = bw_chain[NSLICE];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif

        if (stop_i) begin
            // Abort: count is frozen where it was, no terminal pulse.
            state_d = ST_IDLE;
        end else if (start_i) begin
            cnt_d = load_val_i;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_d = load_val_i;
`endif
            if (load_val_i != '0) begin
                state_d = ST_RUN;
            end else begin
                // Zero-length run finishes immediately with a pulse.
                state_d = ST_DONE;
                tc_d    = 1'b1;
            end
        end else if (state_q == ST_RUN && en_i && !dec_underflow) begin
            if (cnt_q == one_val) begin
                tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                cnt_d = reload_q;
`else
                cnt_d   = '0;
                state_d = ST_DONE;
`endif
            end else begin
                cnt_d = cnt_dec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // Outputs decode registered state only.
    assign cnt_o  = cnt_q;
    assign tc_o   = tc_q;
    assign busy_o = (state_q == ST_RUN);
    assign done_o = (state_q == ST_DONE);

endmodule : down_counter

// File: tb/tb_down_counter.sv
module tb_down_counter;

    localparam int W = 8;

    logic         clk_i;
    logic         rst_ni;
    logic         start_i;
    logic         stop_i;
    logic         en_i;
    logic [W-1:0] load_val_i;
    logic [W-1:0] cnt_o;
    logic         busy_o;
    logic         tc_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .en_i       (en_i),
        .load_val_i (load_val_i),
        .cnt_o      (cnt_o),
        .busy_o     (busy_o),
        .tc_o       (tc_o),
        .done_o     (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         tc;
        logic         done;
    } exp_t;

    exp_t sb[$];

    // Reference model state (0 = idle, 1 = run, 2 = done).
    int           m_state  = 0;
    logic [W-1:0] m_cnt    = '0;
    logic [W-1:0] m_reload = '0;
    logic         m_tc     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_cnt    = '0;
        m_reload = '0;
        m_tc     = 1'b0;
        sb.delete();
    endtask

    // Advance the model by one clock given the inputs of that cycle.
    task automatic model_step(input logic st, input logic sp, input logic en, input logic [W-1:0] ld);
        exp_t e;
        m_tc = 1'b0;
        if (sp) begin
            m_state = 0;
        end else if (st) begin
            m_cnt    = ld;
            m_reload = ld;
            if (ld != 0) m_state = 1;
            else begin
                m_state = 2;
                m_tc    = 1'b1;
            end
        end else if (m_state == 1 && en) begin
            if (m_cnt == 1) begin
                m_tc = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                m_cnt = m_reload;
`else
                m_cnt   = 0;
                m_state = 2;
`endif
            end else begin
                m_cnt = m_cnt - 1'b1;
            end
        end
        e.cnt  = m_cnt;
        e.busy = (m_state == 1);
        e.tc   = m_tc;
        e.done = (m_state == 2);
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, push the expectation, compare after the edge.
    task automatic step(input logic st, input logic sp, input logic en, input logic [W-1:0] ld);
        exp_t e;
        start_i    = st;
        stop_i     = sp;
        en_i       = en;
        load_val_i = ld;
        model_step(st, sp, en, ld);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("cnt_o",  32'(cnt_o),  32'(e.cnt));
            chk("busy_o", 32'(busy_o), 32'(e.busy));
            chk("tc_o",   32'(tc_o),   32'(e.tc));
            chk("done_o", 32'(done_o), 32'(e.done));
        end
    endtask

    initial begin
        int  ticks;
        bit  seen;

        rst_ni     = 1'b0;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        en_i       = 1'b0;
        load_val_i = '0;

        // Reset state
        @(posedge clk_i);
        #1;
        chk("rst_cnt",  32'(cnt_o),  32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tc",   32'(tc_o),   32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_ni = 1'b1;
        model_reset();

        // 1. Asynchronous reset in the middle of a run at cnt=5
        step(1'b1, 1'b0, 1'b0, 8'd5);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("pre_rst_cnt", 32'(cnt_o), 32'd5);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_cnt",  32'(cnt_o),  32'd0);
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_tc",   32'(tc_o),   32'd0);
        chk("async_rst_done", 32'(done_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // 2. load 3, en held high: 3,2,1,0 then terminal handling
        step(1'b1, 1'b0, 1'b1, 8'd3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'd0);
`ifndef DOWN_COUNTER_AUTORELOAD_EN
        chk("t2_done_level", 32'(done_o), 32'd1);
        chk("t2_cnt_zero",   32'(cnt_o),  32'd0);
`endif
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("t2_stop_idle", 32'(done_o), 32'd0);

        // 3. load 4, en toggling: decrement only on enabled cycles
        step(1'b1, 1'b0, 1'b0, 8'd4);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, (i % 2) == 0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);

        // 4. stop beats start at cnt=2; then zero load goes straight to DONE
        step(1'b1, 1'b0, 1'b0, 8'd5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'd0);
        chk("t4_cnt_before", 32'(cnt_o), 32'd2);
        step(1'b1, 1'b1, 1'b1, 8'd9);
        chk("t4_stop_cnt",  32'(cnt_o),  32'd2);
        chk("t4_stop_busy", 32'(busy_o), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        chk("t4_zero_tc",   32'(tc_o),   32'd1);
        chk("t4_zero_done", 32'(done_o), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);

        // 5. slice boundary: 0x10 -> 0x0F, terminal after 16 ticks
        step(1'b1, 1'b0, 1'b0, 8'h10);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        chk("t5_boundary", 32'(cnt_o), 32'h0F);
        ticks = 1;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'd0);
            ticks++;
            if (tc_o) seen = 1'b1;
        end
        chk("t5_tc_seen", 32'(seen),  32'd1);
        chk("t5_ticks",   32'(ticks), 32'd16);
        step(1'b0, 1'b1, 1'b0, 8'd0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // 6. autoreload with period 2
        step(1'b1, 1'b0, 1'b1, 8'd2);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'd0);
            chk("t6_done_low", 32'(done_o), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_down_counter
